// File: rtl/duck_round_ctrl_pkg.sv
// rtl/duck_round_ctrl_pkg.sv - shared state type, widths and defaults for the Duck Hunt round controller
// FLASH_BLANK_EN widens the state type to hold the BLANK state.
package duck_round_ctrl_pkg;

    localparam int SHELL_W = 2;
    localparam int DUCK_W  = 4;

    localparam int DEF_SHELLS          = 3;
    localparam int DEF_DUCKS_PER_ROUND = 10;
    localparam int DEF_HIT_WINDOW      = 4;
    localparam int DEF_FLY_TIMEOUT     = 1000000;

`ifdef FLASH_BLANK_EN
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LAUNCH = 4'd1,
        ST_FLY    = 4'd2,
        ST_FLASH  = 4'd3,
        ST_HIT    = 4'd4,
        ST_ESCAPE = 4'd5,
        ST_NEXT   = 4'd6,
        ST_DONE   = 4'd7,
        ST_BLANK  = 4'd8
    } round_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_FLY    = 3'd2,
        ST_FLASH  = 3'd3,
        ST_HIT    = 3'd4,
        ST_ESCAPE = 3'd5,
        ST_NEXT   = 3'd6,
        ST_DONE   = 3'd7
    } round_state_e;
`endif

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/duck_fly_timer.sv
// rtl/duck_fly_timer.sv - FLY_TIMEOUT countdown with clear, freeze (enable) and done
// Saturates at zero so a frozen-then-resumed duck still reports done.
module duck_fly_timer
    import duck_round_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_FLY_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    localparam int           W    = cnt_width(TIMEOUT);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else if (clear_i) begin
            cnt_q <= LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/duck_round_ctrl.sv
// rtl/duck_round_ctrl.sv - Duck Hunt round sequencer driving the firing FSM leave input
// FLASH_BLANK_EN inserts a one-cycle black frame before each flash to catch aimed-at-lamp cheats.
module duck_round_ctrl
    import duck_round_ctrl_pkg::*;
#(
    parameter int SHELLS          = DEF_SHELLS,
    parameter int DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
    parameter int HIT_WINDOW      = DEF_HIT_WINDOW,
    parameter int FLY_TIMEOUT     = DEF_FLY_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               shot_pulse,
    input  logic               light_sense,
    output logic               gun_leave,
    output logic               duck_launch,
    output logic               duck_hit,
    output logic               duck_escape,
    output logic               flash_req,
    output logic               blank_req,
    output logic [SHELL_W-1:0] shells_left,
    output logic [DUCK_W-1:0]  duck_idx,
    output logic [DUCK_W-1:0]  hits,
    output logic               round_done
);

    localparam int                 WIN_W      = cnt_width(HIT_WINDOW);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(HIT_WINDOW - 1);
    localparam logic [SHELL_W-1:0] SHELL_INIT = SHELL_W'(SHELLS);
    localparam logic [DUCK_W-1:0]  LAST_DUCK  = DUCK_W'(DUCKS_PER_ROUND - 1);

    round_state_e       state_q;
    logic               gun_leave_q;
    logic               duck_launch_q;
    logic               duck_hit_q;
    logic               duck_escape_q;
    logic               flash_req_q;
    logic               round_done_q;
    logic [SHELL_W-1:0] shells_left_q;
    logic [DUCK_W-1:0]  duck_idx_q;
    logic [DUCK_W-1:0]  hits_q;
    logic [WIN_W-1:0]   win_q;
    logic               hit_latch_q;
    logic               fly_done;
    logic               hit_now;

    duck_fly_timer #(.TIMEOUT(FLY_TIMEOUT)) u_fly_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q == ST_LAUNCH),
        .en_i    (state_q == ST_FLY),
        .done_o  (fly_done)
    );

`ifdef FLASH_BLANK_EN
    logic cheat_q;
    logic blank_req_q;
    // Light seen on the black frame means the gun is pointed at a lamp, not the target.
    assign hit_now   = (hit_latch_q | light_sense) & ~cheat_q;
    assign blank_req = blank_req_q;
`else
    assign hit_now   = hit_latch_q | light_sense;
    assign blank_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            gun_leave_q   <= 1'b1;
            duck_launch_q <= 1'b0;
            duck_hit_q    <= 1'b0;
            duck_escape_q <= 1'b0;
            flash_req_q   <= 1'b0;
            round_done_q  <= 1'b0;
            shells_left_q <= '0;
            duck_idx_q    <= '0;
            hits_q        <= '0;
            win_q         <= '0;
            hit_latch_q   <= 1'b0;
`ifdef FLASH_BLANK_EN
            cheat_q       <= 1'b0;
            blank_req_q   <= 1'b0;
`endif
        end else begin
            duck_launch_q <= 1'b0;
            duck_hit_q    <= 1'b0;
            duck_escape_q <= 1'b0;
`ifdef FLASH_BLANK_EN
            blank_req_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q       <= ST_LAUNCH;
                        hits_q        <= '0;
                        duck_idx_q    <= '0;
                        duck_launch_q <= 1'b1;
                        shells_left_q <= SHELL_INIT;
                        gun_leave_q   <= 1'b0;
                        round_done_q  <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_FLY;
                end
                ST_FLY: begin
                    // A shot in the timeout cycle still earns its flash.
                    if (shot_pulse) begin
                        shells_left_q <= shells_left_q - SHELL_W'(1);
                        hit_latch_q   <= 1'b0;
                        win_q         <= '0;
`ifdef FLASH_BLANK_EN
                        state_q       <= ST_BLANK;
                        blank_req_q   <= 1'b1;
`else
                        state_q       <= ST_FLASH;
                        flash_req_q   <= 1'b1;
`endif
                    end else if (fly_done) begin
                        state_q       <= ST_ESCAPE;
                        duck_escape_q <= 1'b1;
                    end
                end
`ifdef FLASH_BLANK_EN
                ST_BLANK: begin
                    cheat_q     <= light_sense;
                    state_q     <= ST_FLASH;
                    flash_req_q <= 1'b1;
                end
`endif
                ST_FLASH: begin
                    if (win_q == WIN_LAST) begin
                        flash_req_q <= 1'b0;
                        if (hit_now) begin
                            state_q    <= ST_HIT;
                            duck_hit_q <= 1'b1;
                            hits_q     <= hits_q + DUCK_W'(1);
                        end else if (shells_left_q == '0) begin
                            state_q       <= ST_ESCAPE;
                            duck_escape_q <= 1'b1;
                        end else begin
                            state_q <= ST_FLY;
                        end
                    end else begin
                        win_q       <= win_q + WIN_W'(1);
                        hit_latch_q <= hit_latch_q | light_sense;
                    end
                end
                ST_HIT, ST_ESCAPE: begin
                    state_q     <= ST_NEXT;
                    gun_leave_q <= 1'b1;
                end
                ST_NEXT: begin
                    if (duck_idx_q == LAST_DUCK) begin
                        state_q      <= ST_DONE;
                        round_done_q <= 1'b1;
                    end else begin
                        state_q       <= ST_LAUNCH;
                        duck_idx_q    <= duck_idx_q + DUCK_W'(1);
                        duck_launch_q <= 1'b1;
                        shells_left_q <= SHELL_INIT;
                        gun_leave_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    gun_leave_q <= 1'b1;
                end
            endcase
        end
    end

    assign gun_leave   = gun_leave_q;
    assign duck_launch = duck_launch_q;
    assign duck_hit    = duck_hit_q;
    assign duck_escape = duck_escape_q;
    assign flash_req   = flash_req_q;
    assign shells_left = shells_left_q;
    assign duck_idx    = duck_idx_q;
    assign hits        = hits_q;
    assign round_done  = round_done_q;

endmodule

// File: doc/duck_round_ctrl.md
Name: duck_round_ctrl

Overview:
Sequences one Duck Hunt round of DUCKS_PER_ROUND ducks on top of the gun firing FSM. Consumes the one-cycle shot pulse (firing FSM entering its SHOT state) and the light-sensor input, and manages shells per duck, the flash hit-detection window, fly-away timeout and hit tally. Drives the firing FSM's leave input so the gun returns to reload between ducks and outside a round.

Parameters:
SHELLS, 3, shells granted per duck (1..3)
DUCKS_PER_ROUND, 10, ducks per round (1..15)
HIT_WINDOW, 4, flash cycles in which light_sense is sampled (>=1)
FLY_TIMEOUT, 1000000, FLY cycles before the duck escapes (>=2)

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
start  in  1  level; begins a round from IDLE or DONE
shot_pulse  in  1  one-cycle pulse per trigger pull (firing FSM SHOT)
light_sense  in  1  gun photodiode, already synchronised
gun_leave  out  1  to firing FSM leave; forces its reload state
duck_launch  out  1  one-cycle pulse, spawn duck
duck_hit  out  1  one-cycle pulse, duck shot
duck_escape  out  1  one-cycle pulse, duck flew away
flash_req  out  1  render hit-box frame (white target on black)
blank_req  out  1  render all-black frame (optional feature; else 0)
shells_left  out  2  shells remaining for current duck
duck_idx  out  4  current duck number, 0-based
hits  out  4  ducks hit this round
round_done  out  1  high while in DONE

Behaviour:
- One clock, async active-high reset; every output registered.
- Reset values: state IDLE, gun_leave=1, all other outputs 0.
- States: IDLE, LAUNCH, FLY, FLASH, HIT, ESCAPE, NEXT, DONE.
- IDLE: gun_leave=1. start -> LAUNCH; hits, duck_idx cleared.
- LAUNCH (1 cycle): duck_launch=1, shells_left<=SHELLS, fly timer<=0, gun_leave<=0 -> FLY.
- FLY: fly timer +1 per cycle. shot_pulse -> shells_left-1, hit latch cleared, window counter 0 -> FLASH. Timer == FLY_TIMEOUT-1 without shot -> ESCAPE. Shot and timeout in the same cycle: the shot wins.
- FLASH: flash_req=1 for exactly HIT_WINDOW cycles. Fly timer frozen. light_sense high in any window cycle sets hit latch. shot_pulse ignored (no shell consumed). After the last window cycle: latch set -> HIT; else shells_left==0 -> ESCAPE; else -> FLY (timer resumes).
- HIT (1 cycle): duck_hit=1, hits+1 -> NEXT.
- ESCAPE (1 cycle): duck_escape=1 -> NEXT.
- NEXT (1 cycle): gun_leave=1. If duck_idx==DUCKS_PER_ROUND-1 -> DONE; else duck_idx+1 -> LAUNCH.
- DONE: round_done=1, gun_leave=1, hits and duck_idx held. start -> clear counters -> LAUNCH.
- shot_pulse outside FLY is ignored. start outside IDLE/DONE is ignored.
- hits cannot overflow: maximum DUCKS_PER_ROUND is 15, which fits in 4 bits.
- Reset mid-round: immediate return to IDLE; an in-flight pulse output drops the same cycle.
- Latency: shot_pulse to flash_req = 1 cycle. Last window cycle to duck_hit = 1 cycle.

Optional Feature:
FLASH_BLANK_EN. Defined: FLY -> BLANK (1 cycle, blank_req=1, shell consumed) -> FLASH. light_sense high during BLANK sets a cheat flag. The cheat flag forces the FLASH outcome to miss (ESCAPE or FLY per shells_left) regardless of the hit latch. Undefined: no BLANK state; blank_req tied 0; shot_pulse to flash_req latency is 1 cycle.

Decomposition:
- Shared package holds: state enum (3-bit encoding), SHELL_W=2, DUCK_W=4, default parameter constants.
- One natural sub-module: duck_fly_timer. It is a FLY_TIMEOUT countdown with clear, enable (freeze) and done outputs, and is reusable for later duck-speed levels.

Test Plan:
- Bench params: DUCKS_PER_ROUND=2, FLY_TIMEOUT=20, HIT_WINDOW=4.
- Hit: start, shot at FLY cycle 5, light_sense high in window cycle 2 -> flash_req high 4 cycles; duck_hit pulse; hits=1; gun_leave pulse; duck_launch for duck_idx=1.
- Three misses: 3 shots with light_sense=0 -> shells_left 2,1,0; after 3rd window, duck_escape with no further FLY; hits unchanged.
- Timeout: no shots -> duck_escape exactly 20 FLY cycles after launch. Shot on cycle 19 -> FLASH taken instead of ESCAPE.
- Round end: two ducks complete -> round_done=1, gun_leave=1, duck_idx=1. start -> hits=0, duck_idx=0, duck_launch.
- Ignored inputs: shot_pulse during FLASH and during IDLE -> shells_left unchanged, no state change.
- Reset asserted in FLASH -> next edge state IDLE, gun_leave=1, flash_req=0.
- FLASH_BLANK_EN build: light_sense high in BLANK and in window -> treated as miss, no duck_hit.
